// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and flag indices for the ALU arbiter
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    AND = 2'd2,
    OR  = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 2-bit-opcode, 32-bit combinational ALU with {N,Z,C,V} flags
module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op,
  output logic [31:0] result,
  output logic [3:0]  flags
);
  import alu_arb_pkg::*;

  logic [32:0] sum;
  logic [32:0] diff;
  logic        carry;
  logic        ovf;
  logic        arith;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    arith  = 1'b0;
    case (alu_op_e'(op))
      ADD: begin
        result = sum[31:0];
        carry  = sum[32];
        ovf    = (a[31] == b[31]) && (sum[31] != a[31]);
        arith  = 1'b1;
      end
      // For SUB the carry bit is a borrow: set when a < b unsigned
      SUB: begin
        result = diff[31:0];
        carry  = diff[32];
        ovf    = (a[31] != b[31]) && (diff[31] != a[31]);
        arith  = 1'b1;
      end
      AND:     result = a & b;
      default: result = a | b;
    endcase
    flags         = '0;
    flags[FLAG_N] = arith & result[31];
    flags[FLAG_Z] = (result == 32'd0);
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/alu_rr_pick.sv
// rtl/alu_rr_pick.sv - combinational round-robin pick starting just above last_grant
module alu_rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic found;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // First pass covers indices above last_grant, second pass wraps around
    for (int j = 0; j < NREQ; j++) begin
      if (!found && valid[j] && (IDW'(j) > last_grant)) begin
        found = 1'b1;
        idx   = IDW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!found && valid[j]) begin
        found = 1'b1;
        idx   = IDW'(j);
      end
    end
    grant = found ? (NREQ'(1) << idx) : '0;
    any   = found;
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU among NREQ valid/ready requesters
// Optional per-requester grant counters with ALU_ARB_PERF_EN.
module alu_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDW   = $clog2(NREQ),
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ-1:0][31:0]       req_a,
  input  logic [NREQ-1:0][31:0]       req_b,
  input  logic [NREQ-1:0][1:0]        req_op,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [IDW-1:0]              rsp_id,
  output logic [31:0]                 rsp_result,
  output logic [3:0]                  rsp_flags
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [NREQ-1:0][CNT_W-1:0]  grant_count
`endif
);
  import alu_arb_pkg::*;

  arb_state_e      state;
  arb_state_e      state_nxt;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  id_q;
  logic [31:0]     a_q;
  logic [31:0]     b_q;
  logic [1:0]      op_q;
  logic [NREQ-1:0] pick_grant;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic            accept;
  logic [31:0]     alu_result;
  logic [3:0]      alu_flags;

  alu_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .idx        (pick_idx),
    .any        (pick_any)
  );

  alu u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result),
    .flags  (alu_flags)
  );

  assign accept = (state == IDLE) && pick_any;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // reset_n gating keeps req_ready low while reset is held with requests pending
  always_comb begin
    req_ready = '0;
    if (reset_n && (state == IDLE)) begin
      req_ready = pick_grant;
    end
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= IDW'(NREQ - 1);
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      if (accept) begin
        a_q        <= req_a[pick_idx];
        b_q        <= req_b[pick_idx];
        op_q       <= req_op[pick_idx];
        id_q       <= pick_idx;
        last_grant <= pick_idx;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_flags  <= alu_flags;
        rsp_id     <= id_q;
      end
    end
  end

`ifdef ALU_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_count <= '0;
    end else if (accept && (grant_count[pick_idx] != {CNT_W{1'b1}})) begin
      grant_count[pick_idx] <= grant_count[pick_idx] + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

  logic            clk;
  logic            reset_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0][1:0] req_op;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [0:0]      rsp_id;
  logic [31:0]     rsp_result;
  logic [3:0]      rsp_flags;
`ifdef ALU_ARB_PERF_EN
  logic [1:0][3:0] grant_count;
`endif

  int vectors;
  int miscompares;

  alu_arbiter #(
    .NREQ  (2),
    .IDW   (1),
    .CNT_W (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags)
`ifdef ALU_ARB_PERF_EN
    ,
    .grant_count (grant_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Single request from requester r, starting in an IDLE cycle with rsp_ready high
  task automatic do_op(input int r, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef);
    logic [1:0] oh;
    oh        = 2'(1 << r);
    req_valid = oh;
    req_op[r] = op;
    req_a[r]  = a;
    req_b[r]  = b;
    #1 chk("op_ready", 32'(req_ready), 32'(oh));
    cyc();
    req_valid = 2'b00;
    #1 chk("op_exec_valid", 32'(rsp_valid), 32'd0);
    chk("op_exec_ready", 32'(req_ready), 32'd0);
    cyc();
    #1 chk("op_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("op_result", rsp_result, er);
    chk("op_flags", 32'(rsp_flags), 32'(ef));
    chk("op_id", 32'(rsp_id), 32'(r));
    cyc();
    #1 chk("op_done", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] e;
    int          ph;
    int          n;
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    req_valid   = '0;
    req_a       = '0;
    req_b       = '0;
    req_op      = '0;
    rsp_ready   = 1'b0;
    cyc();
    cyc();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_flags", 32'(rsp_flags), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    cyc();

    do_op(0, 2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001);
    do_op(1, 2'b01, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b1010);
    do_op(1, 2'b01, 32'd5, 32'd5, 32'h0000_0000, 4'b0100);

    // Both requesters valid from reset: req0 AND, req1 OR
    reset_n   = 1'b0;
    req_valid = 2'b11;
    req_op[0] = 2'b10;
    req_a[0]  = 32'h0000_F0F0;
    req_b[0]  = 32'h0000_FF00;
    req_op[1] = 2'b11;
    req_a[1]  = 32'd0;
    req_b[1]  = 32'd0;
    #1 chk("rst_hold_ready", 32'(req_ready), 32'd0);
    cyc();
    reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      ph = c % 3;
      n  = (c / 3) % 2;
      #1;
      e = (ph == 0) ? ((n == 0) ? 32'd1 : 32'd2) : 32'd0;
      chk("rr_ready", 32'(req_ready), e);
      if (ph == 2) begin
        chk("rr_valid", 32'(rsp_valid), 32'd1);
        chk("rr_id", 32'(rsp_id), 32'(n));
        e = (n == 0) ? 32'h0000_F000 : 32'd0;
        chk("rr_result", rsp_result, e);
      end else begin
        chk("rr_idle_valid", 32'(rsp_valid), 32'd0);
      end
      cyc();
    end

    // Back-pressure: response for req0 held five cycles
    rsp_ready = 1'b0;
    #1 chk("stall_accept", 32'(req_ready), 32'd1);
    cyc();
    cyc();
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_result", rsp_result, 32'h0000_F000);
      chk("stall_id", 32'(rsp_id), 32'd0);
      chk("stall_flags", 32'(rsp_flags), 32'd0);
      chk("stall_ready", 32'(req_ready), 32'd0);
      cyc();
    end
    rsp_ready = 1'b1;
    #1 chk("stall_release_valid", 32'(rsp_valid), 32'd1);
    cyc();
    #1 chk("post_stall_accept", 32'(req_ready), 32'd2);
    cyc();
    cyc();
    #1 chk("post_stall_id", 32'(rsp_id), 32'd1);
    chk("post_stall_flags", 32'(rsp_flags), 32'b0100);
    cyc();
    #1 chk("pre_reset_accept", 32'(req_ready), 32'd1);
    cyc();

    // Reset in EXEC of req0: without it, req1 would be next
    reset_n = 1'b0;
    #1 chk("exec_rst_valid", 32'(rsp_valid), 32'd0);
    chk("exec_rst_ready", 32'(req_ready), 32'd0);
    cyc();
    #1 chk("exec_rst_hold", 32'(rsp_valid), 32'd0);
    cyc();
    reset_n = 1'b1;
    #1 chk("post_rst_grant", 32'(req_ready), 32'd1);
    cyc();
    #1 chk("post_rst_exec", 32'(rsp_valid), 32'd0);
    cyc();
    #1 chk("post_rst_valid", 32'(rsp_valid), 32'd1);
    chk("post_rst_id", 32'(rsp_id), 32'd0);
    chk("post_rst_result", rsp_result, 32'h0000_F000);
    cyc();

`ifdef ALU_ARB_PERF_EN
    reset_n   = 1'b0;
    req_valid = 2'b01;
    #1 chk("perf_rst0", 32'(grant_count[0]), 32'd0);
    cyc();
    reset_n = 1'b1;
    repeat (60) cyc();
    req_valid = 2'b00;
    #1 chk("perf_cnt0", 32'(grant_count[0]), 32'd15);
    chk("perf_cnt1", 32'(grant_count[1]), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one instance of the team's 2-bit-opcode, 32-bit `alu` datapath among `NREQ` requesters. Each requester uses a valid/ready handshake. Grants rotate round-robin, and operands and results are registered. Each response carries the winning requester's ID, the result and the `{N,Z,C,V}` flags. Sits between the execute-stage clients (address unit, compare unit, debug port) and the single ALU.

## Interface
- `NREQ`, default 2: number of requesters, 2..8.
- `IDW`, default `$clog2(NREQ)`: width of the response ID.
- `CNT_W`, default 16: grant-counter width (used only with `ALU_ARB_PERF_EN`).
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in [NREQ]: request pending, one bit per requester.
- `req_ready` out [NREQ]: request accepted this cycle; at most one bit is high.
- `req_a` in [NREQ][32]: operand A.
- `req_b` in [NREQ][32]: operand B.
- `req_op` in [NREQ][2]: opcode. 00 = ADD, 01 = SUB, 10 = AND, 11 = OR.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_id` out [IDW]: index of the requester that owns the response.
- `rsp_result` out 32: ALU result.
- `rsp_flags` out 4: `{N,Z,C,V}`.
- `grant_count` out [NREQ][CNT_W]: present only with `ALU_ARB_PERF_EN`.

## Operation
- FSM states:
  - IDLE: `req_ready` may assert.
  - EXEC: ALU evaluates the registered operands.
  - RESP: `rsp_valid`=1.
- IDLE:
  - If any `req_valid` is high, pick a winner k: the first index above `last_grant` that is valid, searching with wrap-around.
  - Assert `req_ready[k]` combinationally in the same cycle.
  - On the clock edge, capture a/b/op/k and load `last_grant`=k. Go to EXEC.
  - No request: stay in IDLE and drive every `req_ready` to 0.
- EXEC:
  - The ALU is fed only from the operand registers.
  - On the edge, register the result and flags and go to RESP.
- RESP:
  - Hold `rsp_*` stable until `rsp_valid && rsp_ready`, then go to IDLE.
  - `req_ready` stays at 0 for the whole state.
- Arithmetic and flags:
  - ADD and SUB use a 33-bit unsigned A±B. C = bit 32, so for SUB, C=1 means borrow (A<B unsigned).
  - V is signed overflow.
  - N = result[31].
  - Z = (result == 0).
  - AND and OR: N=C=V=0; Z is computed.
- Requesters must hold `req_valid` and their operands until ready. Withdrawing a request early is a protocol violation; the arbiter does not need to handle it.
- Reset state:
  - Entered asynchronously at any time.
  - State = IDLE, `last_grant` = NREQ-1 (requester 0 wins first).
  - `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_flags` all 0; `req_ready` all 0; counters 0.
  - A reset in EXEC or RESP drops the in-flight operation with no response.

## Timing
- Accept in cycle N, EXEC in cycle N+1, `rsp_valid`=1 from cycle N+2.
- Minimum 3 cycles per operation when `rsp_ready` is held high.
- A response handshake in cycle M returns to IDLE, so the next accept can happen in cycle M+1.
- No path from `rsp_ready` to `req_ready` within the same cycle.
- `req_ready` depends combinationally on `req_valid`, the state and `last_grant` only.

## Configuration
- `ALU_ARB_PERF_EN` defined:
  - Adds the `grant_count` port.
  - Counter k increments on each accept by requester k and saturates at 2^CNT_W-1.
  - Counters are cleared only by reset.
- Not defined: no port, no counter logic. All other behaviour is identical.

## Structure
- Package `alu_arb_pkg` holds:
  - the `alu_op_e` enum (ADD/SUB/AND/OR = 0..3);
  - the `arb_state_e` enum (IDLE/EXEC/RESP);
  - the flag index constants `FLAG_N`=3, `FLAG_Z`=2, `FLAG_C`=1, `FLAG_V`=0.
- Sub-module `alu_rr_pick`: purely combinational. Takes the valid vector and `last_grant`; returns a one-hot grant and its index.
- The existing `alu` module is instantiated once and fed from the operand registers.

## Test plan
- req0: ADD 0x7FFFFFFF + 0x00000001. Expected: `rsp_valid` 2 cycles after accept, result 0x80000000, flags 1001, `rsp_id`=0.
- req1: SUB 3 − 5. Expected: result 0xFFFFFFFE, flags 1010. Then SUB 5 − 5. Expected: result 0, flags 0100.
- Both requesters valid continuously from reset, `rsp_ready`=1. Expected grant order 0,1,0,1, and one response every 3 cycles.
- `rsp_ready` held at 0 for 5 cycles during RESP. Expected: `rsp_*` stable throughout, both `req_ready` at 0. When `rsp_ready` rises, the handshake completes and the next accept follows in the next cycle.
- `reset_n` pulsed low during EXEC. Expected: `rsp_valid` is 0 immediately, no response is issued, and after reset the next grant goes to requester 0.
- With `ALU_ARB_PERF_EN` and CNT_W=4: 20 grants to req0. Expected `grant_count[0]`=15, `grant_count[1]`=0.
